fft_stage_ctrl: RTL and testbench
=================================

Name: fft_stage_ctrl

Overview:
- Sequencer for an in-place radix-2 DIT FFT held in a single N-word dual-address sample memory (separate read and write address pairs).
- On start, walks all LOG_N stages and N/2 butterflies per stage. Per butterfly it issues read addresses, a twiddle index and a valid pulse to a fixed-latency butterfly unit.
- Writes results back to the same addresses BF_LATENCY cycles later, draining the pipeline between stages to avoid read-after-write hazards.

Parameters:
- N, 8, FFT length (power of two, >= 4).
- LOG_N, 3, log2(N).
- BF_LATENCY, 2, butterfly pipeline latency in cycles (>= 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin transform; sampled only in IDLE
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the final write has committed
- error  out  1  sticky error flag
- stage  out  LOG_N  current stage index s
- rd_addr0  out  LOG_N  butterfly upper-input read address
- rd_addr1  out  LOG_N  butterfly lower-input read address
- tw_addr  out  LOG_N-1  twiddle ROM index
- bf_valid  out  1  rd_addr*/tw_addr valid; butterfly consumes them this cycle
- bf_ret_valid  in  1  butterfly output valid (expected BF_LATENCY after bf_valid)
- wr_addr0  out  LOG_N  write-back address for butterfly output 0
- wr_addr1  out  LOG_N  write-back address for butterfly output 1
- wr_en  out  1  memory write strobe for both write addresses

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, error=0, stage=0, rd_addr*=0, tw_addr=0, bf_valid=0, wr_addr*=0, wr_en=0. The delay line is cleared. The state is IDLE.
- Reset asserted mid-transform aborts the run. The cycle after rst_n is sampled low, no further bf_valid or wr_en occurs. A pending write is discarded.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: start=1 -> RUN with s=0, b=0, busy=1. start=0 -> stay.
- RUN: for each cycle with bf_valid=1, counter b (0..N/2-1) produces:
  - half = 2^s; pos = b & (half-1); grp = b >> s.
  - rd_addr0 = grp*2*half + pos; rd_addr1 = rd_addr0 + half.
  - tw_addr = pos << (LOG_N-1-s), truncated to LOG_N-1 bits.
  - b increments each cycle. After b=N/2-1 is issued -> DRAIN.
- DRAIN: lasts exactly BF_LATENCY cycles with bf_valid=0. On exit:
  - if s<LOG_N-1: s+1, b=0 -> RUN;
  - otherwise -> FIN.
- FIN: done=1 and busy=0 for one cycle -> IDLE.
- Timing, with start sampled at cycle 0:
  - stage k first bf_valid at cycle 1+k*(N/2+BF_LATENCY);
  - done at cycle LOG_N*(N/2+BF_LATENCY)+1.
- Write path:
  - wr_en = bf_valid delayed exactly BF_LATENCY cycles.
  - wr_addr0/1 = rd_addr0/1 delayed BF_LATENCY cycles.
  - No write occurs without a matching earlier issue.
- Hazard rule: the last write of stage k occurs in the final DRAIN cycle. The first read of stage k+1 occurs the following cycle.
- Error conditions; error is sticky until reset:
  - bf_ret_valid differs from internal delayed valid (wr_en) in any cycle;
  - start=1 while busy=1. The start is ignored and the run continues unaffected.
- start in the FIN cycle is ignored without error. start in IDLE the cycle after done is accepted.
- error does not halt sequencing.

Test Plan:
- N=8, BF_LATENCY=2, pulse start at cycle 0 -> bf_valid cycles 1-4, 7-10, 13-16; done at cycle 19 only. The (rd_addr0, rd_addr1, tw_addr) sequences are:
  - stage0: (0,1,0)(2,3,0)(4,5,0)(6,7,0);
  - stage1: (0,2,0)(1,3,2)(4,6,0)(5,7,2);
  - stage2: (0,4,0)(1,5,1)(2,6,2)(3,7,3).
- Same run, bf_ret_valid driven from the bench model with delay 2 -> wr_en at cycles 3-6, 9-12, 15-18 with wr_addr equal to the rd_addr issued 2 cycles earlier; error stays 0; wr_en=0 at cycle 19.
- bf_ret_valid held low throughout the run -> error rises at cycle 4 (first expected return, one cycle after the compare) and stays 1 through done and IDLE until reset.
- start re-pulsed at cycle 5 during the run -> error=1; address sequence and done cycle are identical to the first scenario.
- rst_n low at cycle 8 (mid stage1) -> from cycle 9 busy=0, bf_valid=0, wr_en=0, error=0, stage=0. A fresh start then reproduces the first scenario exactly.
- Back-to-back: start asserted again in the cycle after done -> the second transform begins next cycle with stage=0 and identical timing; no error.

Source files
------------

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT sequencer: issues butterfly read/twiddle addresses
// stage by stage and writes results back after a fixed butterfly latency.
module fft_stage_ctrl #(
  parameter int N          = 8,
  parameter int LOG_N      = 3,
  parameter int BF_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LOG_N-1:0] stage,
  output logic [LOG_N-1:0] rd_addr0,
  output logic [LOG_N-1:0] rd_addr1,
  output logic [LOG_N-2:0] tw_addr,
  output logic             bf_valid,
  input  logic             bf_ret_valid,
  output logic [LOG_N-1:0] wr_addr0,
  output logic [LOG_N-1:0] wr_addr1,
  output logic             wr_en
);

  localparam int DW = $clog2(BF_LATENCY + 1);
  localparam logic [LOG_N-1:0] LAST_B = LOG_N'(N / 2 - 1);
  localparam logic [LOG_N-1:0] LAST_S = LOG_N'(LOG_N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t           r_state;
  logic [LOG_N-1:0] r_b;
  logic [DW-1:0]    r_dcnt;
  logic             r_busy, r_done, r_error, r_bf_valid;
  logic [LOG_N-1:0] r_stage, r_rd0, r_rd1;
  logic [LOG_N-2:0] r_tw;

  logic [BF_LATENCY-1:0]            r_vld_pipe;
  logic [BF_LATENCY-1:0][LOG_N-1:0] r_wa0_pipe, r_wa1_pipe;

  logic [LOG_N-1:0] w_iss_s, w_iss_b, w_half, w_pos, w_grp, w_rd0, w_rd1, w_tw_sh;
  logic [LOG_N-2:0] w_tw;

  // Butterfly that the next issue cycle will present: first of a stage when
  // leaving IDLE/DRAIN, otherwise the successor of the one on the outputs.
  always_comb begin
    w_iss_s = r_stage;
    w_iss_b = r_b + 1'b1;
    if (r_state == IDLE) begin
      w_iss_s = '0;
      w_iss_b = '0;
    end else if (r_state == DRAIN) begin
      w_iss_s = r_stage + 1'b1;
      w_iss_b = '0;
    end
    w_half  = LOG_N'(1) << w_iss_s;
    w_pos   = w_iss_b & (w_half - 1'b1);
    w_grp   = w_iss_b >> w_iss_s;
    w_rd0   = (w_grp << (w_iss_s + 1'b1)) | w_pos;
    w_rd1   = w_rd0 + w_half;
    w_tw_sh = LAST_S - w_iss_s;
    w_tw    = (LOG_N-1)'(w_pos << w_tw_sh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_b        <= '0;
      r_dcnt     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_bf_valid <= 1'b0;
      r_stage    <= '0;
      r_rd0      <= '0;
      r_rd1      <= '0;
      r_tw       <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= r_error | (bf_ret_valid != r_vld_pipe[BF_LATENCY-1]) | (start & r_busy);
      case (r_state)
        IDLE: if (start) begin
          r_state    <= RUN;
          r_busy     <= 1'b1;
          r_bf_valid <= 1'b1;
          r_stage    <= w_iss_s;
          r_b        <= w_iss_b;
          r_rd0      <= w_rd0;
          r_rd1      <= w_rd1;
          r_tw       <= w_tw;
        end
        RUN: if (r_b == LAST_B) begin
          r_state    <= DRAIN;
          r_bf_valid <= 1'b0;
          r_dcnt     <= DW'(1);
        end else begin
          r_b   <= w_iss_b;
          r_rd0 <= w_rd0;
          r_rd1 <= w_rd1;
          r_tw  <= w_tw;
        end
        // Hold off the next stage until its last write has committed.
        DRAIN: if (r_dcnt == DW'(BF_LATENCY)) begin
          if (r_stage == LAST_S) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= RUN;
            r_bf_valid <= 1'b1;
            r_stage    <= w_iss_s;
            r_b        <= w_iss_b;
            r_rd0      <= w_rd0;
            r_rd1      <= w_rd1;
            r_tw       <= w_tw;
          end
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_wa0_pipe <= '0;
      r_wa1_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= r_bf_valid;
      r_wa0_pipe[0] <= r_rd0;
      r_wa1_pipe[0] <= r_rd1;
      for (int i = 1; i < BF_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_wa0_pipe[i] <= r_wa0_pipe[i-1];
        r_wa1_pipe[i] <= r_wa1_pipe[i-1];
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign stage    = r_stage;
  assign rd_addr0 = r_rd0;
  assign rd_addr1 = r_rd1;
  assign tw_addr  = r_tw;
  assign bf_valid = r_bf_valid;
  assign wr_en    = r_vld_pipe[BF_LATENCY-1];
  assign wr_addr0 = r_wa0_pipe[BF_LATENCY-1];
  assign wr_addr1 = r_wa1_pipe[BF_LATENCY-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl: a butterfly-order model queues the expected
// issues, writes and done pulses; a negedge monitor pops and compares them.
module tb_fft_stage_ctrl;
  localparam int N = 8, LOG_N = 3, L = 2;
  localparam int RUN_LEN = LOG_N * (N / 2 + L);
  localparam int INF = 32'h7fffffff;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bf_ret_valid;
  logic busy, done, error, bf_valid, wr_en;
  logic [LOG_N-1:0] stage, rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [LOG_N-2:0] tw_addr;

  fft_stage_ctrl #(.N(N), .LOG_N(LOG_N), .BF_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .stage(stage), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .tw_addr(tw_addr),
    .bf_valid(bf_valid), .bf_ret_valid(bf_ret_valid), .wr_addr0(wr_addr0),
    .wr_addr1(wr_addr1), .wr_en(wr_en));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Butterfly unit stand-in: echoes bf_valid L cycles later when enabled.
  logic [L-1:0] ret_sr = '0;
  logic ret_en = 1'b1;
  always @(posedge clk) begin
    if (!rst_n) ret_sr <= '0;
    else        ret_sr <= (ret_sr << 1) | L'(bf_valid);
  end
  assign bf_ret_valid = ret_en & ret_sr[L-1];

  typedef struct { int c; int s; int a0; int a1; int tw; } iss_t;
  typedef struct { int c; int a0; int a1; } wr_t;
  iss_t iss_q[$];
  wr_t  wr_q[$];
  int   done_q[$];

  int vectors = 0, miscompares = 0;
  int err_at = INF, bz_lo = INF, bz_hi = -1;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input bit ok, input string detail);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: %s", name, cyc, detail);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected behaviour of one transform started (sampled) at cycle t0.
  task automatic model_run(input int t0);
    for (int s = 0; s < LOG_N; s++) begin
      int half = 1 << s;
      int k = 0;
      for (int base = 0; base < N; base += 2 * half)
        for (int pos = 0; pos < half; pos++) begin
          iss_t e;
          wr_t  w;
          e.c = t0 + 1 + s * (N / 2 + L) + k;
          e.s = s; e.a0 = base + pos; e.a1 = base + pos + half;
          e.tw = pos * (N / (2 * half));
          iss_q.push_back(e);
          w.c = e.c + L; w.a0 = e.a0; w.a1 = e.a1;
          wr_q.push_back(w);
          k++;
        end
    end
    done_q.push_back(t0 + RUN_LEN + 1);
    bz_lo = t0 + 1;
    bz_hi = t0 + RUN_LEN;
  endtask

  always @(negedge clk) if (mon_en) begin
    iss_t e;
    wr_t  w;
    int   d;
    if (bf_valid) begin
      if (iss_q.size() == 0) chk("issue_extra", 1'b0, $sformatf("got s=%0d a0=%0d a1=%0d want none", stage, rd_addr0, rd_addr1));
      else begin
        e = iss_q.pop_front();
        chk("issue", e.c == cyc && e.s == int'(stage) && e.a0 == int'(rd_addr0) && e.a1 == int'(rd_addr1) && e.tw == int'(tw_addr),
            $sformatf("got cyc=%0d s=%0d a0=%0d a1=%0d tw=%0d want cyc=%0d s=%0d a0=%0d a1=%0d tw=%0d",
                      cyc, stage, rd_addr0, rd_addr1, tw_addr, e.c, e.s, e.a0, e.a1, e.tw));
      end
    end else if (iss_q.size() > 0 && iss_q[0].c <= cyc) begin
      e = iss_q.pop_front();
      chk("issue_missing", 1'b0, $sformatf("got bf_valid=0 want issue a0=%0d a1=%0d", e.a0, e.a1));
    end
    if (wr_en) begin
      if (wr_q.size() == 0) chk("write_extra", 1'b0, $sformatf("got wr a0=%0d a1=%0d want none", wr_addr0, wr_addr1));
      else begin
        w = wr_q.pop_front();
        chk("write", w.c == cyc && w.a0 == int'(wr_addr0) && w.a1 == int'(wr_addr1),
            $sformatf("got cyc=%0d a0=%0d a1=%0d want cyc=%0d a0=%0d a1=%0d", cyc, wr_addr0, wr_addr1, w.c, w.a0, w.a1));
      end
    end else if (wr_q.size() > 0 && wr_q[0].c <= cyc) begin
      w = wr_q.pop_front();
      chk("write_missing", 1'b0, $sformatf("got wr_en=0 want write a0=%0d a1=%0d", w.a0, w.a1));
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_extra", 1'b0, "got done=1 want 0");
      else begin
        d = done_q.pop_front();
        chk("done", d == cyc, $sformatf("got done at %0d want %0d", cyc, d));
      end
    end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
      d = done_q.pop_front();
      chk("done_missing", 1'b0, $sformatf("got done=0 want done at %0d", d));
    end
    chk("busy", busy == (cyc >= bz_lo && cyc <= bz_hi), $sformatf("got %0b want %0b", busy, (cyc >= bz_lo && cyc <= bz_hi)));
    chk("error", error == (cyc >= err_at), $sformatf("got %0b want %0b", error, (cyc >= err_at)));
  end

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    iss_q.delete(); wr_q.delete(); done_q.delete();
    err_at = INF; bz_lo = INF; bz_hi = -1;
    chk("reset_ctl", {busy, done, error, bf_valid, wr_en} == 5'b0 && stage == '0,
        $sformatf("got busy=%0b done=%0b err=%0b bfv=%0b wen=%0b stage=%0d want all 0", busy, done, error, bf_valid, wr_en, stage));
    chk("reset_addr", rd_addr0 == '0 && rd_addr1 == '0 && tw_addr == '0 && wr_addr0 == '0 && wr_addr1 == '0,
        $sformatf("got rd=%0d,%0d tw=%0d wr=%0d,%0d want 0", rd_addr0, rd_addr1, tw_addr, wr_addr0, wr_addr1));
    mon_en = 1'b1;
  endtask

  // spur/rst_at are offsets from the start cycle (-1 = none); b2b leaves start
  // high through the FIN cycle and into the following IDLE cycle.
  task automatic run(input int gap, input int spur, input bit ret_low, input int rst_at, input bit b2b);
    int t0, d;
    repeat (gap) begin start = 1'b0; tick(); end
    t0 = cyc;
    d  = t0 + RUN_LEN + 1;
    start  = 1'b1;
    ret_en = !ret_low;
    model_run(t0);
    if (ret_low && t0 + L + 2 < err_at) err_at = t0 + L + 2;
    tick();
    while (cyc <= d) begin
      start = 1'b0;
      if (cyc == t0 + rst_at) begin do_reset(); return; end
      if (cyc == t0 + spur) begin
        start = 1'b1;
        if (cyc + 1 < err_at) err_at = cyc + 1;
      end
      if (b2b && cyc == d) start = 1'b1;
      tick();
    end
    chk("drained", iss_q.size() == 0 && wr_q.size() == 0 && done_q.size() == 0,
        $sformatf("got pending iss=%0d wr=%0d done=%0d want 0", iss_q.size(), wr_q.size(), done_q.size()));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit prev_b2b;
    do_reset();
    run(2, -1, 1'b0, -1, 1'b1);   // nominal, start held through FIN into IDLE
    run(0, -1, 1'b0, -1, 1'b0);   // back-to-back transform
    run(3, 5, 1'b0, -1, 1'b0);    // start re-pulsed mid-run
    do_reset();
    run(1, -1, 1'b1, -1, 1'b0);   // butterfly never returns
    run(2, -1, 1'b0, -1, 1'b0);   // error stays sticky
    do_reset();
    run(2, -1, 1'b0, 8, 1'b0);    // reset mid stage1
    run(1, -1, 1'b0, -1, 1'b0);
    prev_b2b = 1'b0;
    for (int i = 0; i < 24; i++) begin
      int gap, spur, rst_at;
      bit low, b2b;
      gap    = prev_b2b ? 0 : int'($urandom_range(0, 3));
      spur   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, RUN_LEN)) : -1;
      low    = ($urandom_range(0, 5) == 0);
      rst_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, RUN_LEN)) : -1;
      b2b    = ($urandom_range(0, 2) == 0);
      run(gap, spur, low, rst_at, b2b);
      prev_b2b = b2b && rst_at < 0;
    end
    start = 1'b0;
    repeat (4) tick();
    chk("idle_end", busy == 1'b0 && bf_valid == 1'b0, $sformatf("got busy=%0b bfv=%0b want 0", busy, bf_valid));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
